// File: rtl/data_mem_bank.sv
// data_mem_bank
//   Byte-addressable single-port data memory with a valid/ready request
//   channel and a valid/ready response channel. One request may be in
//   flight at a time. Writes are committed and reads captured on the
//   acceptance edge; the response appears LATENCY cycles later and is
//   held until the requester takes it.
//
// Parameters
//   DATA_WIDTH  : word width in bits (32 or 64)
//   DEPTH_BYTES : storage size in bytes (power of two)
//   LATENCY     : acceptance-to-response latency in cycles (1..8)
//
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req_*        : request channel (valid, byte address, write enable,
//                    little-endian write data, byte-lane mask)
//   o_req_ready    : high only while idle
//   o_rsp_*        : response channel (valid, read data, error)
//   i_rsp_ready    : requester takes the response
module data_mem_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [31:0]             i_req_addr,
  input  logic                    i_req_wen,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_mask,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_err
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH_BYTES);
  localparam int CNT_W  = 3;
  // WAIT is entered with LATENCY-2 so that RESP lands exactly LATENCY
  // cycles after acceptance; unused when LATENCY is 1.
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [7:0]              mem [DEPTH_BYTES];

  logic                    accept;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    req_err;
  logic                    mem_we;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Reset also blocks acceptance so a request cannot slip into storage
  // on an edge that arrives while reset is held.
  assign accept       = i_req_valid && req_ready_q && i_rst_n;
  assign misaligned   = |i_req_addr[OFF_W-1:0];
  // 33-bit sum so addresses near 2^32 cannot wrap into range.
  assign out_of_range = ({1'b0, i_req_addr} + 33'(NBYTES)) > 33'(DEPTH_BYTES);
  assign req_err      = misaligned || out_of_range;
  assign idx          = i_req_addr[IDX_W-1:0];
  assign mem_we       = accept && i_req_wen && !req_err;

  // Little-endian word assembly: lane k comes from byte address idx+k.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NBYTES; k++) begin
      rd_word[8*k +: 8] = mem[idx + IDX_W'(k)];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_req_mask[k]) begin
          mem[idx + IDX_W'(k)] <= i_req_wdata[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_err_d   = req_err;
          rsp_rdata_d = (!i_req_wen && !req_err) ? rd_word : '0;
          req_ready_d = 1'b0;
          if (LATENCY == 1) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// tb_data_mem_bank
//   Drives two instances of data_mem_bank: instance A (32-bit, LATENCY 1)
//   and instance B (64-bit, LATENCY 4), both 1024 bytes. A shared request
//   bus is steered to one instance at a time by 'sel'. A byte-array model
//   per instance supplies expected read data and error flags.
module tb_data_mem_bank;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_wen;
  logic        rsp_ready;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_mask;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [63:0] rsp_rdata_b;

  logic        valid_a_in, valid_b_in, rready_a_in, rready_b_in;
  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [63:0] rsp_rdata_s;

  int errors;
  int checks;

  logic [7:0] model [2][1024];

  localparam int NERR = 14;
  localparam logic [31:0] ERR_ADDR [NERR] = '{
    32'h0000_0002, 32'h0000_03FC, 32'h0000_0400, 32'hFFFF_FFF8, 32'h0000_03F8,
    32'h0000_0002, 32'h0000_03FC, 32'h0000_0400, 32'h0000_03FE, 32'h0000_0400,
    32'h0000_03F8, 32'h0000_0000, 32'h0000_0008, 32'h0000_03FC};
  localparam logic [NERR-1:0] ERR_SEL = 14'b00_0111_1111_1111;
  localparam logic [NERR-1:0] ERR_WEN = 14'b00_0001_1110_0000;

  assign valid_a_in  = req_valid & ~sel;
  assign valid_b_in  = req_valid & sel;
  assign rready_a_in = rsp_ready & ~sel;
  assign rready_b_in = rsp_ready & sel;
  assign req_ready_s = sel ? req_ready_b : req_ready_a;
  assign rsp_valid_s = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_err_s   = sel ? rsp_err_b : rsp_err_a;
  assign rsp_rdata_s = sel ? rsp_rdata_b : {32'h0, rsp_rdata_a};

  data_mem_bank #(.DATA_WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid_a_in), .o_req_ready(req_ready_a),
    .i_req_addr(req_addr), .i_req_wen(req_wen),
    .i_req_wdata(req_wdata[31:0]), .i_req_mask(req_mask[3:0]),
    .o_rsp_valid(rsp_valid_a), .i_rsp_ready(rready_a_in),
    .o_rsp_rdata(rsp_rdata_a), .o_rsp_err(rsp_err_a)
  );

  data_mem_bank #(.DATA_WIDTH(64), .DEPTH_BYTES(1024), .LATENCY(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid_b_in), .o_req_ready(req_ready_b),
    .i_req_addr(req_addr), .i_req_wen(req_wen),
    .i_req_wdata(req_wdata), .i_req_mask(req_mask),
    .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rready_b_in),
    .o_rsp_rdata(rsp_rdata_b), .o_rsp_err(rsp_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nbytes(input bit s);
    return s ? 8 : 4;
  endfunction

  function automatic int lat_of(input bit s);
    return s ? 4 : 1;
  endfunction

  function automatic bit exp_err(input bit s, input logic [31:0] addr);
    longint a;
    a = {32'h0, addr};
    return ((a % nbytes(s)) != 0) || ((a + nbytes(s)) > 1024);
  endfunction

  function automatic logic [63:0] exp_read(input bit s, input logic [31:0] addr);
    logic [63:0] r;
    r = '0;
    if (exp_err(s, addr)) return r;
    for (int k = 0; k < nbytes(s); k++) r[8*k +: 8] = model[s][int'(addr[9:0]) + k];
    return r;
  endfunction

  task automatic model_write(input bit s, input logic [31:0] addr,
                             input logic [63:0] wdata, input logic [7:0] mask);
    if (exp_err(s, addr)) return;
    for (int k = 0; k < nbytes(s); k++)
      if (mask[k]) model[s][int'(addr[9:0]) + k] = wdata[8*k +: 8];
  endtask

  // Full transaction: present the request, then keep valid high with junk
  // writes while busy, hold the response for 'hold' cycles, take it.
  // lat = -1 on any timeout; proto_ok collects ready/stability rules.
  task automatic xact(input bit s, input logic [31:0] addr, input bit wen,
                      input logic [63:0] wdata, input logic [7:0] mask, input int hold,
                      output logic [63:0] rdata, output logic err, output int lat,
                      output bit proto_ok);
    int guard;
    proto_ok = 1'b1;
    rdata    = '0;
    err      = 1'b0;
    lat      = -1;
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_addr = addr; req_wen = wen;
    req_wdata = wdata; req_mask = mask; rsp_ready = 1'b0;
    #1;
    guard = 0;
    while (req_ready_s !== 1'b1 && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 20) begin
      req_valid = 1'b0; proto_ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_addr  = $urandom_range(0, 127) * 8;
    req_wen   = 1'b1;
    req_wdata = {$urandom, $urandom};
    req_mask  = 8'hFF;
    lat = 1;
    guard = 0;
    while (rsp_valid_s !== 1'b1 && guard < 20) begin
      if (req_ready_s !== 1'b0) proto_ok = 1'b0;
      @(posedge clk); #1; lat++; guard++;
    end
    if (guard >= 20) begin
      req_valid = 1'b0; lat = -1;
      return;
    end
    if (req_ready_s !== 1'b0) proto_ok = 1'b0;
    rdata = rsp_rdata_s;
    err   = rsp_err_s;
    repeat (hold) begin
      @(posedge clk); #1;
      if (rsp_valid_s !== 1'b1 || rsp_rdata_s !== rdata || rsp_err_s !== err ||
          req_ready_s !== 1'b0) proto_ok = 1'b0;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (req_ready_s !== 1'b1 || rsp_valid_s !== 1'b0) proto_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid_a, rsp_err_a, rsp_rdata_a} !== 34'h0) begin
      errors++; $display("[TB] FAIL reset_rsp_a: got %h expected 0", {rsp_valid_a, rsp_err_a, rsp_rdata_a});
    end
    checks++;
    if ({rsp_valid_b, rsp_err_b, rsp_rdata_b} !== 66'h0) begin
      errors++; $display("[TB] FAIL reset_rsp_b: got %h expected 0", {rsp_valid_b, rsp_err_b, rsp_rdata_b});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({req_ready_a, req_ready_b} !== 2'b11) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 11", {req_ready_a, req_ready_b});
    end
  endtask

  // Writes every word of both instances so later reads never see X.
  task automatic test_fill;
    logic [63:0] rd, wd;
    logic e;
    int lat;
    bit ok;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 1024; a += nbytes(s[0])) begin
        wd = {$urandom, $urandom};
        if (s == 0) wd[63:32] = '0;
        xact(s[0], a, 1'b1, wd, 8'hFF, 0, rd, e, lat, ok);
        model_write(s[0], a, wd, 8'hFF);
        checks++;
        if (e !== 1'b0 || rd !== 64'h0 || lat != lat_of(s[0]) || !ok) begin
          errors++;
          $display("[TB] FAIL fill_write s=%0d a=%h: got err=%b rdata=%h lat=%0d ok=%b expected err=0 rdata=0 lat=%0d ok=1",
                   s, a, e, rd, lat, ok, lat_of(s[0]));
        end
      end
    end
  endtask

  task automatic test_directed;
    logic [63:0] rd;
    logic e;
    int lat;
    bit ok;
    xact(1'b0, 32'h10, 1'b1, 64'hDEADBEEF, 8'h0F, 0, rd, e, lat, ok);
    model_write(1'b0, 32'h10, 64'hDEADBEEF, 8'h0F);
    checks++;
    if (e !== 1'b0 || rd !== 64'h0 || lat != 1) begin
      errors++; $display("[TB] FAIL dir_write10: got err=%b rdata=%h lat=%0d expected 0 0 1", e, rd, lat);
    end
    xact(1'b0, 32'h10, 1'b0, 64'h0, 8'h0F, 0, rd, e, lat, ok);
    checks++;
    if (e !== 1'b0 || rd !== 64'hDEADBEEF) begin
      errors++; $display("[TB] FAIL dir_read10: got err=%b rdata=%h expected 0 deadbeef", e, rd);
    end
    xact(1'b0, 32'h20, 1'b1, 64'h11223344, 8'h0F, 0, rd, e, lat, ok);
    model_write(1'b0, 32'h20, 64'h11223344, 8'h0F);
    xact(1'b0, 32'h20, 1'b1, 64'hAABBCCDD, 8'h05, 0, rd, e, lat, ok);
    model_write(1'b0, 32'h20, 64'hAABBCCDD, 8'h05);
    xact(1'b0, 32'h20, 1'b0, 64'h0, 8'h00, 0, rd, e, lat, ok);
    checks++;
    if (e !== 1'b0 || rd !== 64'h11BB33DD) begin
      errors++; $display("[TB] FAIL dir_mask0101: got err=%b rdata=%h expected 0 11bb33dd", e, rd);
    end
    xact(1'b0, 32'h10, 1'b1, 64'h12345678, 8'h00, 0, rd, e, lat, ok);
    checks++;
    if (e !== 1'b0 || rd !== 64'h0) begin
      errors++; $display("[TB] FAIL dir_mask0_write: got err=%b rdata=%h expected 0 0", e, rd);
    end
    xact(1'b0, 32'h10, 1'b0, 64'h0, 8'h0F, 0, rd, e, lat, ok);
    checks++;
    if (rd !== 64'hDEADBEEF) begin
      errors++; $display("[TB] FAIL dir_mask0_kept: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_errors;
    logic [63:0] rd, wd, er;
    logic e, ee;
    int lat;
    bit ok;
    for (int i = 0; i < NERR; i++) begin
      wd = {$urandom, $urandom};
      if (!ERR_SEL[i]) wd[63:32] = '0;
      ee = exp_err(ERR_SEL[i], ERR_ADDR[i]);
      er = ERR_WEN[i] ? 64'h0 : exp_read(ERR_SEL[i], ERR_ADDR[i]);
      xact(ERR_SEL[i], ERR_ADDR[i], ERR_WEN[i], wd, 8'hFF, 0, rd, e, lat, ok);
      if (ERR_WEN[i]) model_write(ERR_SEL[i], ERR_ADDR[i], wd, 8'hFF);
      checks++;
      if (e !== ee || rd !== er || !ok) begin
        errors++;
        $display("[TB] FAIL err_case%0d a=%h: got err=%b rdata=%h ok=%b expected err=%b rdata=%h ok=1",
                 i, ERR_ADDR[i], e, rd, ok, ee, er);
      end
    end
  endtask

  task automatic test_latency;
    logic [63:0] rd, er;
    logic e;
    int lat;
    bit ok;
    for (int s = 1; s >= 0; s--) begin
      er = exp_read(s[0], 32'h3F8);
      xact(s[0], 32'h3F8, 1'b0, 64'h0, 8'h00, 3, rd, e, lat, ok);
      checks++;
      if (lat != lat_of(s[0]) || !ok || rd !== er || e !== 1'b0) begin
        errors++;
        $display("[TB] FAIL latency_s%0d: got lat=%0d ok=%b rdata=%h expected lat=%0d ok=1 rdata=%h",
                 s, lat, ok, rd, lat_of(s[0]), er);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] rd, wd, er;
    logic [31:0] addr;
    logic [7:0] mask;
    logic e, ee;
    bit s, wen, ok;
    int lat, hold, r;
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 7)      addr = $urandom_range(0, 1024 / nbytes(s) - 1) * nbytes(s);
      else if (r < 8) addr = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
      else if (r < 9) addr = 1024 + $urandom_range(0, 63) * nbytes(s);
      else            addr = $urandom;
      wen  = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      mask = 8'($urandom);
      if (!s) begin
        wd[63:32] = '0; mask[7:4] = '0;
      end
      hold = $urandom_range(0, 3);
      ee = exp_err(s, addr);
      er = wen ? 64'h0 : exp_read(s, addr);
      xact(s, addr, wen, wd, mask, hold, rd, e, lat, ok);
      if (wen) model_write(s, addr, wd, mask);
      checks++;
      if (e !== ee || rd !== er || lat != lat_of(s) || !ok) begin
        errors++;
        $display("[TB] FAIL rand%0d s=%0d a=%h wen=%b: got err=%b rdata=%h lat=%0d ok=%b expected err=%b rdata=%h lat=%0d ok=1",
                 i, s, addr, wen, e, rd, lat, ok, ee, er, lat_of(s));
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [63:0] rd;
    logic e;
    int lat;
    bit ok;
    @(negedge clk);
    sel = 1'b1; req_valid = 1'b1; req_addr = 32'h40; req_wen = 1'b1;
    req_wdata = 64'h0123_4567_89AB_CDEF; req_mask = 8'hFF; rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready_s !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_ready_before: got %b expected 1", req_ready_s);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_write(1'b1, 32'h40, 64'h0123_4567_89AB_CDEF, 8'hFF);
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid_s, req_ready_s} !== 2'b00) begin
      errors++; $display("[TB] FAIL mid_in_wait: got %b expected 00", {rsp_valid_s, req_ready_s});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid_s !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_async_valid: got %b expected 0", rsp_valid_s);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid_s, req_ready_s} !== 2'b01) begin
      errors++; $display("[TB] FAIL mid_after_release: got %b expected 01", {rsp_valid_s, req_ready_s});
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid_s !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_rsp_discarded: got %b expected 0", rsp_valid_s);
    end
    xact(1'b1, 32'h40, 1'b0, 64'h0, 8'h00, 0, rd, e, lat, ok);
    checks++;
    if (rd !== 64'h0123_4567_89AB_CDEF || e !== 1'b0 || lat != 4) begin
      errors++; $display("[TB] FAIL mid_read40: got rdata=%h err=%b lat=%0d expected 0123456789abcdef 0 4", rd, e, lat);
    end
    // Reset while a read response is waiting to be taken.
    @(negedge clk);
    sel = 1'b1; req_valid = 1'b1; req_addr = 32'h40; req_wen = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid_s !== 1'b1 || rsp_rdata_s !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("[TB] FAIL resp_before_reset: got valid=%b rdata=%h expected 1 0123456789abcdef", rsp_valid_s, rsp_rdata_s);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid_s, rsp_err_s, rsp_rdata_s} !== 66'h0) begin
      errors++; $display("[TB] FAIL resp_async_clear: got %h expected 0", {rsp_valid_s, rsp_err_s, rsp_rdata_s});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid_s, req_ready_s} !== 2'b01) begin
      errors++; $display("[TB] FAIL resp_after_release: got %b expected 01", {rsp_valid_s, req_ready_s});
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_mask = '0; rst_n = 1'b0;
    test_reset();
    test_fill();
    test_directed();
    test_errors();
    test_latency();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
